// File: rtl/lock_key_pkg.sv
// Shared constants, FSM state encoding and checksum fold for the c432 key loader.
// The optional lockout feature is enabled by defining KEY_LOCKOUT_EN.
package lock_key_pkg;

   localparam int P_W      = 4;
   localparam int X_W      = 43;
   localparam int CHK_W    = 8;
   localparam int K        = P_W + X_W;
   localparam int MAX_FAIL = 3;
   localparam int N_CHUNK  = (K + CHK_W - 1) / CHK_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT_KEY,
      ST_SHIFT_CHK,
      ST_COMMIT,
      ST_LOCKOUT
   } state_t;

   // Bit j of the result is the XOR of every key bit k with k mod CHK_W == j,
   // which is the same as XOR-ing the key together CHK_W bits at a time.
   function automatic logic [CHK_W-1:0] chk_fold(input logic [K-1:0] v);
      logic [N_CHUNK*CHK_W-1:0] pad;
      logic [CHK_W-1:0]         r;
      pad = (N_CHUNK*CHK_W)'(v);
      r   = '0;
      for (int c = 0; c < N_CHUNK; c++) begin
         r   = r ^ pad[CHK_W-1:0];
         pad = pad >> CHK_W;
      end
      return r;
   endfunction

endpackage

// File: rtl/lock_key_shifter.sv
// Serial-in capture register: each qualified bit lands at index cnt; o_done latches
// once all W bits are in, and further bits are ignored until the next restart.
module lock_key_shifter #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_restart,
   input  logic         i_en,
   input  logic         i_vld,
   input  logic         i_sdi,
   output logic [W-1:0] o_data,
   output logic         o_done
);

   localparam int            CW   = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_data;
   logic          r_done;
   logic          w_take;

   assign w_take = i_en & i_vld & ~r_done;
   assign o_data = r_data;
   assign o_done = r_done;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_data <= '0;
         r_done <= 1'b0;
      end else if (i_restart) begin
         r_cnt  <= '0;
         r_data <= '0;
         r_done <= 1'b0;
      end else if (w_take) begin
         r_data[r_cnt] <= i_sdi;
         if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_done <= 1'b1;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/lock_key_loader.sv
// Receives a framed serial key plus checksum, verifies it and holds the active
// key for the locked c432 core. Define KEY_LOCKOUT_EN for failure lockout.
module lock_key_loader
   import lock_key_pkg::*;
(
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_key_start,
   input  logic           i_key_bit_vld,
   input  logic           i_key_sdi,
   input  logic           i_key_clear,
   output logic [P_W-1:0] o_p_key,
   output logic [X_W-1:0] o_x_key,
   output logic           o_key_ready,
   output logic           o_key_err,
   output logic           o_busy,
   output logic           o_locked_out
);

   state_t           r_state;
   state_t           w_next;
   logic [P_W-1:0]   r_pKey;
   logic [X_W-1:0]   r_xKey;
   logic             r_keyReady;
   logic [K-1:0]     w_shadow;
   logic [CHK_W-1:0] w_chkRx;
   logic             w_keyDone;
   logic             w_chkDone;
   logic             w_restart;
   logic             w_keyEn;
   logic             w_chkEn;
   logic             w_match;
   logic             w_commitOk;
   logic             w_err;
   logic             w_busy;
   logic             w_lastFail;
   logic             w_zeroize;

   lock_key_shifter #(.W(K)) u_keyShift (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_restart (w_restart),
      .i_en      (w_keyEn),
      .i_vld     (i_key_bit_vld),
      .i_sdi     (i_key_sdi),
      .o_data    (w_shadow),
      .o_done    (w_keyDone)
   );

   lock_key_shifter #(.W(CHK_W)) u_chkShift (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_restart (w_restart),
      .i_en      (w_chkEn),
      .i_vld     (i_key_bit_vld),
      .i_sdi     (i_key_sdi),
      .o_data    (w_chkRx),
      .o_done    (w_chkDone)
   );

   assign w_match = (chk_fold(w_shadow) == w_chkRx);

`ifdef KEY_LOCKOUT_EN
   localparam int             FCW       = $clog2(MAX_FAIL + 1);
   localparam logic [FCW-1:0] FAIL_LAST = FCW'(MAX_FAIL - 1);
   localparam logic [FCW-1:0] FAIL_MAX  = FCW'(MAX_FAIL);

   logic [FCW-1:0] r_failCnt;

   // Saturating count of consecutive checksum mismatches; a good commit clears it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_failCnt <= '0;
      end else if (w_commitOk) begin
         r_failCnt <= '0;
      end else if (w_err && (r_failCnt != FAIL_MAX)) begin
         r_failCnt <= r_failCnt + FCW'(1);
      end
   end

   assign w_lastFail   = (r_failCnt == FAIL_LAST);
   assign w_zeroize    = i_key_clear | (w_next == ST_LOCKOUT);
   assign o_locked_out = (r_state == ST_LOCKOUT);
`else
   assign w_lastFail   = 1'b0;
   assign w_zeroize    = i_key_clear;
   assign o_locked_out = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // The checksum shifter is also enabled in the last SHIFT_KEY cycle, so the
   // first checksum bit may directly follow the last key bit.
   always_comb begin
      w_next     = r_state;
      w_restart  = 1'b0;
      w_keyEn    = 1'b0;
      w_chkEn    = 1'b0;
      w_commitOk = 1'b0;
      w_err      = 1'b0;
      w_busy     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_key_start) begin
               w_restart = 1'b1;
               w_next    = ST_SHIFT_KEY;
            end
         end
         ST_SHIFT_KEY: begin
            w_busy  = 1'b1;
            w_keyEn = 1'b1;
            w_chkEn = w_keyDone;
            if (i_key_start) begin
               w_restart = 1'b1;
            end else if (w_keyDone) begin
               w_next = ST_SHIFT_CHK;
            end
         end
         ST_SHIFT_CHK: begin
            w_busy  = 1'b1;
            w_chkEn = 1'b1;
            if (i_key_start) begin
               w_restart = 1'b1;
               w_next    = ST_SHIFT_KEY;
            end else if (w_chkDone) begin
               w_next = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            w_busy     = 1'b1;
            w_commitOk = w_match;
            w_err      = ~w_match;
            w_next     = (w_err && w_lastFail) ? ST_LOCKOUT : ST_IDLE;
         end
         ST_LOCKOUT: begin
            w_next = ST_LOCKOUT;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Active key only moves on commit, clear or lockout, so the core sees no glitches.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pKey     <= '0;
         r_xKey     <= '0;
         r_keyReady <= 1'b0;
      end else if (w_zeroize) begin
         r_pKey     <= '0;
         r_xKey     <= '0;
         r_keyReady <= 1'b0;
      end else if (w_commitOk) begin
         r_pKey     <= w_shadow[P_W-1:0];
         r_xKey     <= w_shadow[K-1:P_W];
         r_keyReady <= 1'b1;
      end
   end

   assign o_p_key     = r_pKey;
   assign o_x_key     = r_xKey;
   assign o_key_ready = r_keyReady;
   assign o_key_err   = w_err;
   assign o_busy      = w_busy;

endmodule

// File: tb/tb_lock_key_loader.sv
// Self-checking bench for lock_key_loader; expected commit results are queued
// per frame and compared when the DUT commits. Honours KEY_LOCKOUT_EN.
module tb_lock_key_loader;

   localparam int KB = 47;

`ifdef KEY_LOCKOUT_EN
   localparam bit LOCK_BUILD = 1'b1;
`else
   localparam bit LOCK_BUILD = 1'b0;
`endif

   typedef struct {
      logic        err;
      logic [3:0]  p;
      logic [42:0] x;
      logic        ready;
      logic        locked;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        keyStart;
   logic        keyBitVld;
   logic        keySdi;
   logic        keyClear;
   logic [3:0]  pKey;
   logic [42:0] xKey;
   logic        keyReady;
   logic        keyErr;
   logic        busy;
   logic        lockedOut;

   exp_t        sbq[$];
   int          nVec = 0;
   int          nMis = 0;

   logic [3:0]  mP;
   logic [42:0] mX;
   logic        mReady;
   logic        mLocked;
   int          mFail;

   always #5 clk = ~clk;

   lock_key_loader dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_key_start   (keyStart),
      .i_key_bit_vld (keyBitVld),
      .i_key_sdi     (keySdi),
      .i_key_clear   (keyClear),
      .o_p_key       (pKey),
      .o_x_key       (xKey),
      .o_key_ready   (keyReady),
      .o_key_err     (keyErr),
      .o_busy        (busy),
      .o_locked_out  (lockedOut)
   );

   // Independent reference fold: bit j collects every key bit with k mod 8 == j.
   function automatic logic [7:0] chk_fold(input logic [46:0] v);
      logic [46:0] t;
      logic [7:0]  r;
      t = v;
      r = '0;
      for (int k = 0; k < KB; k++) begin
         r = {r[0] ^ t[0], r[7:1]};
         t = t >> 1;
      end
      // After 47 rotations the accumulator is offset by 47 mod 8 = 7 positions.
      return {r[0], r[7:1]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic modelReset();
      mP      = '0;
      mX      = '0;
      mReady  = 1'b0;
      mLocked = 1'b0;
      mFail   = 0;
   endtask

   // Drives start plus n bits of a frame image, LSB first; stall inserts two idle cycles per bit.
   task automatic applyStimulus(input logic [54:0] frame, input int n, input bit stall, input logic expBusy);
      logic [54:0] f;
      f = frame;
      keyStart = 1'b1;
      tick();
      keyStart = 1'b0;
      for (int i = 0; i < n; i++) begin
         keyBitVld = 1'b1;
         keySdi    = f[0];
         f         = f >> 1;
         tick();
         keyBitVld = 1'b0;
         if (stall && (i < 54)) begin
            for (int s = 0; s < 2; s++) begin
               keySdi = 1'($urandom);
               tick();
               nVec++;
               if (busy !== expBusy) begin
                  nMis++;
                  $display("[TB] FAIL stall_busy bit %0d: got %b expected %b", i, busy, expBusy);
               end
            end
         end
      end
   endtask

   task automatic sendFrame(input logic [46:0] key, input logic [7:0] chk, input bit stall,
                            input bit clr, input string name);
      exp_t        e;
      logic        lockedBefore;
      logic [3:0]  prevP;
      logic        prevReady;
      logic        ok;
      lockedBefore = mLocked;
      prevP        = mP;
      prevReady    = mReady;
      ok           = (chk_fold(key) == chk);
      e.err        = 1'b0;
      if (!mLocked) begin
         if (ok) begin
            mFail = 0;
            if (clr) begin
               mP = '0; mX = '0; mReady = 1'b0;
            end else begin
               mP = key[3:0]; mX = key[46:4]; mReady = 1'b1;
            end
         end else begin
            e.err = 1'b1;
            mFail++;
            if (clr) begin
               mP = '0; mX = '0; mReady = 1'b0;
            end
            if (LOCK_BUILD && (mFail >= 3)) begin
               mLocked = 1'b1;
               mP = '0; mX = '0; mReady = 1'b0;
            end
         end
      end
      e.p = mP; e.x = mX; e.ready = mReady; e.locked = mLocked;
      sbq.push_back(e);

      applyStimulus({chk, key}, 55, stall, !lockedBefore);

      // Edge that captured the last checksum bit: nothing visible yet.
      nVec++;
      if ((keyReady !== prevReady) || (pKey !== prevP) || (keyErr !== 1'b0)) begin
         nMis++;
         $display("[TB] FAIL %s early: got ready=%b p=%h err=%b expected ready=%b p=%h err=0",
                  name, keyReady, pKey, keyErr, prevReady, prevP);
      end
      tick();
      nVec++;
      if ((keyErr !== e.err) || (busy !== !lockedBefore)) begin
         nMis++;
         $display("[TB] FAIL %s commit_cycle: got err=%b busy=%b expected err=%b busy=%b",
                  name, keyErr, busy, e.err, !lockedBefore);
      end
      nVec++;
      if ((pKey !== prevP) || (keyReady !== prevReady)) begin
         nMis++;
         $display("[TB] FAIL %s held_in_commit: got p=%h ready=%b expected p=%h ready=%b",
                  name, pKey, keyReady, prevP, prevReady);
      end
      keyClear = clr;
      tick();
      keyClear = 1'b0;
      e = sbq.pop_front();
      nVec++;
      if ((pKey !== e.p) || (xKey !== e.x) || (keyReady !== e.ready) ||
          (lockedOut !== e.locked) || (keyErr !== 1'b0)) begin
         nMis++;
         $display("[TB] FAIL %s result: got p=%h x=%h ready=%b lock=%b err=%b expected p=%h x=%h ready=%b lock=%b err=0",
                  name, pKey, xKey, keyReady, lockedOut, keyErr, e.p, e.x, e.ready, e.locked);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; keyStart = 1'b0; keyBitVld = 1'b0; keySdi = 1'b0; keyClear = 1'b0;
      modelReset();
      tick();
      tick();
      nVec++;
      if ({pKey, xKey, keyReady, keyErr, busy, lockedOut} !== '0) begin
         nMis++;
         $display("[TB] FAIL reset_outputs: got p=%h x=%h ready=%b err=%b busy=%b lock=%b expected all 0",
                  pKey, xKey, keyReady, keyErr, busy, lockedOut);
      end
      rst = 1'b0;
      tick();
      nVec++;
      if (busy !== 1'b0) begin
         nMis++;
         $display("[TB] FAIL idle_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_all_ones();
      logic [46:0] k;
      k = '1;
      sendFrame(k, chk_fold(k), 1'b0, 1'b0, "all_ones");
   endtask

   task automatic test_sparse();
      logic [46:0] k;
      k = 47'h12;
      sendFrame(k, 8'h12, 1'b0, 1'b0, "sparse_good");
      sendFrame(k, 8'h13, 1'b0, 1'b0, "sparse_badchk");
   endtask

   task automatic test_stall();
      logic [46:0] k;
      k = {$urandom, $urandom};
      sendFrame(k, chk_fold(k), 1'b1, 1'b0, "stalled");
   endtask

   task automatic test_abort();
      logic [46:0] a;
      logic [46:0] b;
      logic [3:0]  prevP;
      a = 47'h5A5A_1234_5678;
      b = 47'h0F0F_0000_ABCD;
      prevP = mP;
      applyStimulus({chk_fold(a), a}, 20, 1'b0, 1'b1);
      nVec++;
      if ((busy !== 1'b1) || (pKey !== prevP)) begin
         nMis++;
         $display("[TB] FAIL abort_partial: got busy=%b p=%h expected busy=1 p=%h", busy, pKey, prevP);
      end
      sendFrame(b, chk_fold(b), 1'b0, 1'b0, "restarted");
   endtask

   task automatic test_clear_commit();
      logic [46:0] k;
      k = 47'h7FFF_0000_0003;
      sendFrame(k, chk_fold(k), 1'b0, 1'b1, "clear_at_commit");
   endtask

   task automatic test_lockout();
      logic [46:0] k;
      logic [46:0] g;
      k = '1;
      g = 47'h1234_5678_9AB;
      for (int n = 0; n < 3; n++) begin
         sendFrame(k, chk_fold(k) ^ 8'h01, 1'b0, 1'b0, $sformatf("bad_%0d", n));
      end
      sendFrame(g, chk_fold(g), 1'b0, 1'b0, "fourth_good");
      keyClear = 1'b1;
      tick();
      keyClear = 1'b0;
      if (!mLocked) begin
         mP = '0; mX = '0; mReady = 1'b0;
      end
      nVec++;
      if ((lockedOut !== mLocked) || (pKey !== mP) || (keyReady !== mReady)) begin
         nMis++;
         $display("[TB] FAIL clear_after_seq: got lock=%b p=%h ready=%b expected lock=%b p=%h ready=%b",
                  lockedOut, pKey, keyReady, mLocked, mP, mReady);
      end
      rst = 1'b1;
      #2;
      rst = 1'b0;
      modelReset();
      tick();
      nVec++;
      if ((lockedOut !== 1'b0) || (busy !== 1'b0) || (pKey !== 4'h0) || (keyReady !== 1'b0)) begin
         nMis++;
         $display("[TB] FAIL post_reset: got lock=%b busy=%b p=%h ready=%b expected all 0",
                  lockedOut, busy, pKey, keyReady);
      end
      sendFrame(g, chk_fold(g), 1'b0, 1'b0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_all_ones();
      test_sparse();
      test_stall();
      test_abort();
      test_clear_commit();
      test_lockout();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
